// File: rtl/mcu_dequant_unzigzag.sv
// Dequantize a zigzag-ordered 8x8 coefficient stream into a raster-ordered block.
// Define MCU_DEQUANT_EOB_EN to enable early end-of-block zero fill.
module mcu_dequant_unzigzag #(
  parameter int COEF_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COEF_W-1:0]       in_coef,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_eob,
  output logic [7:0][7:0][31:0]   mcu,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {FILL, ZERO, FULL} state_e;

  // Raster index (row*8+col) of each zigzag position.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  // Luminance quant table, raster order.
  localparam logic [7:0] QT [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99};

  state_e                  state_q;
  logic [5:0]              k_q;
  logic [7:0][7:0][31:0]   mcu_q;
  logic                    in_ready_q, out_valid_q;

  logic                    accept, eob;
  logic [5:0]              pos;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [31:0]      coef_x, q_x, prod;

  assign accept = in_valid && in_ready_q;
  assign pos    = ZZ[k_q];
  assign coef_s = in_coef;
  assign coef_x = 32'(coef_s);
  assign q_x    = {24'd0, QT[pos]};
  assign prod   = coef_x * q_x;

`ifdef MCU_DEQUANT_EOB_EN
  assign eob = in_eob;
`else
  logic unused_eob;
  assign unused_eob = in_eob;
  assign eob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      k_q         <= '0;
      mcu_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: if (accept) begin
          mcu_q[pos[5:3]][pos[2:0]] <= prod;
          if (k_q == 6'd63) begin
            state_q     <= FULL;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 6'd1;
            if (eob) begin
              state_q    <= ZERO;
              in_ready_q <= 1'b0;
            end
          end
        end
        // One trailing position cleared per cycle after an early end-of-block.
        ZERO: begin
          mcu_q[pos[5:3]][pos[2:0]] <= '0;
          if (k_q == 6'd63) begin
            state_q     <= FULL;
            k_q         <= '0;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 6'd1;
          end
        end
        FULL: if (out_ready) begin
          state_q     <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= FILL;
          k_q         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mcu       = mcu_q;

endmodule

// File: tb/tb_mcu_dequant_unzigzag.sv
// Randomized bench for mcu_dequant_unzigzag against a zigzag/quant reference model.
module tb_mcu_dequant_unzigzag;
  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           in_coef;
  logic                  in_valid, in_ready, in_eob;
  logic [7:0][7:0][31:0] mcu;
  logic                  out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  int QK [8][8] = '{
    '{16, 11, 10, 16, 24, 40, 51, 61},
    '{12, 12, 14, 19, 26, 58, 60, 55},
    '{14, 13, 16, 24, 40, 57, 69, 56},
    '{14, 17, 22, 29, 51, 87, 80, 62},
    '{18, 22, 37, 56, 68,109,103, 77},
    '{24, 35, 55, 64, 81,104,113, 92},
    '{49, 64, 78, 87,103,121,120,101},
    '{72, 92, 95, 98,112,100,103, 99}};
  int zr [64];
  int zc [64];

`ifdef MCU_DEQUANT_EOB_EN
  localparam bit EOB_BUILD = 1'b1;
`else
  localparam bit EOB_BUILD = 1'b0;
`endif

  mcu_dequant_unzigzag #(.COEF_W(16)) dut (
    .clk(clk), .reset(reset), .in_coef(in_coef), .in_valid(in_valid),
    .in_ready(in_ready), .in_eob(in_eob), .mcu(mcu), .out_valid(out_valid),
    .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Walk the anti-diagonals: odd ones go down-left, even ones up-right.
  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s <= 14; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zr[k] = r; zc[k] = s - r; k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zr[k] = r; zc[k] = s - r; k++; end
      end
    end
  endtask

  task automatic check_block(input string tag, input int coefs [64]);
    int e [8][8];
    for (int k = 0; k < 64; k++) e[zr[k]][zc[k]] = coefs[k] * QK[zr[k]][zc[k]];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c), mcu[r][c], 32'(e[r][c]));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_coef  = 16'($urandom);
    in_eob   = 1'($urandom);
  endtask

  task automatic push(input int c, input bit eob, input int gap);
    int t = 0;
    repeat (gap) begin @(negedge clk); idle_inputs(); end
    @(negedge clk);
    in_valid = 1'b1; in_coef = 16'(c); in_eob = eob;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("push_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_valid(input int max);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < max) begin @(negedge clk); t++; end
    chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  // Handshake with garbage on the input side to prove there is no bypass.
  task automatic release_block();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_coef = 16'($urandom);
    @(posedge clk); #1;
    out_ready = 1'b0; idle_inputs();
    @(negedge clk);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rel_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk [64];
    int blk2 [64];
    int n;
    build_zigzag();
    reset = 1'b1; out_ready = 1'b0; idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mcu00", mcu[0][0], 32'd0);
    chk("rst_mcu77", mcu[7][7], 32'd0);

    // All ones, back to back, end-of-block flag on the last one.
    for (int k = 0; k < 64; k++) begin blk[k] = 1; push(1, k == 63, 0); end
    @(negedge clk);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_in_ready",  {31'd0, in_ready},  32'd0);
    check_block("ones", blk);

    // Hold in FULL while the producer keeps offering data.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_coef = 16'($urandom); in_eob = 1'b0;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(negedge clk) idle_inputs();
    check_block("hold", blk);
    release_block();

    // Sign handling.
    for (int k = 0; k < 64; k++) blk[k] = 0;
    blk[0] = -2; blk[2] = 3;
    for (int k = 0; k < 64; k++) push(blk[k], 1'b0, 0);
    wait_valid(5);
    chk("neg_mcu00", mcu[0][0], 32'hFFFF_FFE0);
    chk("neg_mcu10", mcu[1][0], 32'd36);
    check_block("sign", blk);
    release_block();

    // Two random blocks with gaps, second starting right after the handshake.
    for (int k = 0; k < 64; k++) begin
      blk[k]  = int'($urandom_range(0, 65535)) - 32768;
      blk2[k] = int'($urandom_range(0, 4095)) - 2048;
    end
    for (int k = 0; k < 64; k++)
      push(blk[k], EOB_BUILD ? 1'b0 : 1'($urandom), $urandom_range(0, 3));
    wait_valid(10);
    check_block("rnd1", blk);
    release_block();
    for (int k = 0; k < 64; k++)
      push(blk2[k], EOB_BUILD ? 1'b0 : 1'($urandom), (k == 0) ? 0 : $urandom_range(0, 3));
    wait_valid(10);
    check_block("rnd2", blk2);
    release_block();

    // Reset mid-block discards the partial block.
    for (int k = 0; k < 30; k++) push(7, 1'b0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_mcu00", mcu[0][0], 32'd0);
    for (int k = 0; k < 64; k++) begin blk[k] = 2; push(2, 1'b0, 0); end
    wait_valid(5);
    check_block("twos", blk);
    release_block();

    if (EOB_BUILD) begin
      // Early end-of-block at k=0 zero-fills the remaining 63 positions.
      push(5, 1'b1, 0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        chk("eob_in_ready", {31'd0, in_ready}, 32'd0);
        n++;
        @(negedge clk);
      end
      chk("eob_zero_cycles", 32'(n), 32'd63);
      for (int k = 0; k < 64; k++) blk[k] = 0;
      blk[0] = 5;
      chk("eob_mcu00", mcu[0][0], 32'd80);
      check_block("eob", blk);
      release_block();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
